uart_rx_frame_ctrl: RTL and testbench

//  Receive-side frame controller for the AES-over-UART link. Takes bytes from the UART Rx
//  (one rx_valid pulse per byte) and assembles them into a PAYLOAD_BYTES block (an AES block by default).

---
 rtl/uart_rx_frame_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side frame controller: assembles UART bytes into a payload block, checks the
// trailing CRC-16/CCITT-FALSE and holds the frame until acked. CRC path enabled by RX_CRC_CHECK_EN.
module uart_rx_frame_ctrl #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_frame_err,
  input  logic                       frame_ack,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic [15:0]                rx_crc,
  output logic                       frame_valid,
  output logic                       crc_ok,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_framing,
  output logic                       overrun
);

  localparam int CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef RX_CRC_CHECK_EN
  typedef enum logic [2:0] {IDLE, RECV_PAYLOAD, RECV_CRC, CHECK, HOLD} state_e;
  localparam state_e AFTER_PAYLOAD = RECV_CRC;
`else
  typedef enum logic [2:0] {IDLE, RECV_PAYLOAD, CHECK, HOLD} state_e;
  localparam state_e AFTER_PAYLOAD = CHECK;
`endif

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TO_W-1:0]            idle_q, idle_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       busy_q, busy_d;
  logic                       err_timeout_q, err_timeout_d;
  logic                       err_framing_q, err_framing_d;
  logic                       overrun_q, overrun_d;
  logic                       store, abort, tick_idle;

`ifdef RX_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] rx_crc_q, rx_crc_d;
  logic        crc_ok_q, crc_ok_d;

  // CRC-16/CCITT-FALSE, MSB first, one byte per call
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idle_q        <= '0;
      payload_q     <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_framing_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc_q         <= 16'hFFFF;
      rx_crc_q      <= 16'h0000;
      crc_ok_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      payload_q     <= payload_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_framing_q <= err_framing_d;
      overrun_q     <= overrun_d;
`ifdef RX_CRC_CHECK_EN
      crc_q         <= crc_d;
      rx_crc_q      <= rx_crc_d;
      crc_ok_q      <= crc_ok_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    payload_d     = payload_q;
    frame_valid_d = frame_valid_q;
    err_timeout_d = 1'b0;
    err_framing_d = 1'b0;
    overrun_d     = 1'b0;
    store         = 1'b0;
    abort         = 1'b0;
    tick_idle     = 1'b0;
`ifdef RX_CRC_CHECK_EN
    crc_d         = crc_q;
    rx_crc_d      = rx_crc_q;
    crc_ok_d      = crc_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && rx_valid) store = 1'b1;
      end
      RECV_PAYLOAD: begin
        if (rx_frame_err) begin
          abort         = 1'b1;
          err_framing_d = 1'b1;
        end else if (rx_valid) begin
          store = 1'b1;
        end else begin
          tick_idle = 1'b1;
        end
      end
`ifdef RX_CRC_CHECK_EN
      RECV_CRC: begin
        if (rx_frame_err) begin
          abort         = 1'b1;
          err_framing_d = 1'b1;
        end else if (rx_valid) begin
          idle_d = '0;
          if (!cnt_q[0]) begin
            rx_crc_d[15:8] = rx_byte;
            cnt_d          = CNT_W'(1);
          end else begin
            rx_crc_d[7:0] = rx_byte;
            cnt_d         = '0;
            state_d       = CHECK;
          end
        end else begin
          tick_idle = 1'b1;
        end
      end
`endif
      CHECK: begin
        frame_valid_d = 1'b1;
        state_d       = HOLD;
`ifdef RX_CRC_CHECK_EN
        crc_ok_d      = (crc_q == rx_crc_q);
`endif
      end
      HOLD: begin
        if (rx_valid) overrun_d = 1'b1;
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = IDLE;
`ifdef RX_CRC_CHECK_EN
          crc_d         = 16'hFFFF;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // byte[cnt] lands in payload with byte 0 in the MSBs
    if (store) begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) payload_d[8*(PAYLOAD_BYTES-1-i) +: 8] = rx_byte;
      end
`ifdef RX_CRC_CHECK_EN
      crc_d = crc16_upd(crc_q, rx_byte);
`endif
      idle_d = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = AFTER_PAYLOAD;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = RECV_PAYLOAD;
      end
    end

    if (tick_idle) begin
      if (idle_q == TO_LAST) begin
        abort         = 1'b1;
        err_timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idle_d  = '0;
`ifdef RX_CRC_CHECK_EN
      crc_d   = 16'hFFFF;
`endif
    end

`ifdef RX_CRC_CHECK_EN
    busy_d = (state_d == RECV_PAYLOAD) || (state_d == RECV_CRC) || (state_d == CHECK);
`else
    busy_d = (state_d == RECV_PAYLOAD) || (state_d == CHECK);
`endif
  end

  assign payload     = payload_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_framing = err_framing_q;
  assign overrun     = overrun_q;
`ifdef RX_CRC_CHECK_EN
  assign rx_crc      = rx_crc_q;
  assign crc_ok      = crc_ok_q;
`else
  assign rx_crc      = 16'h0000;
  assign crc_ok      = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (PAYLOAD_BYTES=9, TIMEOUT_CYCLES=50); adapts to RX_CRC_CHECK_EN.
module tb_uart_rx_frame_ctrl;

  localparam int PB = 9;
  localparam int TO = 50;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_frame_err = 1'b0;
  logic          frame_ack = 1'b0;
  logic [8*PB-1:0] payload;
  logic [15:0]   rx_crc;
  logic          frame_valid, crc_ok, busy, err_timeout, err_framing, overrun;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [71:0] P_DIGITS = 72'h313233343536373839;

  uart_rx_frame_ctrl #(.PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_frame_err(rx_frame_err), .frame_ack(frame_ack), .payload(payload),
    .rx_crc(rx_crc), .frame_valid(frame_valid), .crc_ok(crc_ok), .busy(busy),
    .err_timeout(err_timeout), .err_framing(err_framing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // "123456789" plus CRC bytes 0x29,crc_lo when the CRC path is built
  task automatic send_frame(input logic [7:0] crc_lo);
    logic [71:0] digits;
    digits = P_DIGITS;
    for (int i = 0; i < PB; i++) send(digits[8*(PB-1-i) +: 8]);
    if (CRC_EN) begin
      send(8'h29);
      send(crc_lo);
    end
  endtask

  task automatic check_frame(input string tag, input logic exp_ok, input logic [15:0] exp_crc);
    check({tag, ".fv_check"}, 128'(frame_valid), 128'(0));
    check({tag, ".busy_check"}, 128'(busy), 128'(1));
    tick();
    check({tag, ".fv"}, 128'(frame_valid), 128'(1));
    check({tag, ".crc_ok"}, 128'(crc_ok), 128'(exp_ok));
    check({tag, ".payload"}, 128'(payload), 128'(P_DIGITS));
    check({tag, ".rx_crc"}, 128'(rx_crc), 128'(exp_crc));
    check({tag, ".busy_hold"}, 128'(busy), 128'(0));
  endtask

  task automatic ack_frame(input string tag);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check({tag, ".fv_after_ack"}, 128'(frame_valid), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".payload"}, 128'(payload), 128'(0));
    check({tag, ".rx_crc"}, 128'(rx_crc), 128'(0));
    check({tag, ".fv"}, 128'(frame_valid), 128'(0));
    check({tag, ".crc_ok"}, 128'(crc_ok), 128'(CRC_EN ? 1'b0 : 1'b1));
    check({tag, ".busy"}, 128'(busy), 128'(0));
    check({tag, ".flags"}, 128'({err_timeout, err_framing, overrun}), 128'(0));
  endtask

  initial begin
    // 1: reset with rx_valid toggling, then en=0 bytes are ignored
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = ~rx_valid;
      rx_byte  = 8'h50 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    reset    = 1'b0;
    check_all_zero("t1.reset");
    send(8'h41);
    send(8'h42);
    send(8'h43);
    tick();
    check_all_zero("t1.en0");

    // 2: good frame
    en = 1'b1;
    send_frame(8'hB1);
    check_frame("t2", 1'b1, CRC_EN ? 16'h29B1 : 16'h0000);
    ack_frame("t2");

    // 3: corrupted CRC low byte
    send_frame(8'hB0);
    check_frame("t3", CRC_EN ? 1'b0 : 1'b1, CRC_EN ? 16'h29B0 : 16'h0000);
    ack_frame("t3");

    // 4: five bytes then silence -> timeout 50 cycles after the 5th byte is taken
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    check("t4.busy", 128'(busy), 128'(1));
    for (int i = 0; i < TO - 1; i++) tick();
    check("t4.no_to_yet", 128'(err_timeout), 128'(0));
    tick();
    check("t4.err_timeout", 128'(err_timeout), 128'(1));
    check("t4.busy_idle", 128'(busy), 128'(0));
    check("t4.payload_kept", 128'(payload), 128'(72'hA0A1A2A3A4_36373839));
    tick();
    check("t4.to_pulse_end", 128'(err_timeout), 128'(0));
    send_frame(8'hB1);
    check_frame("t4.retry", 1'b1, CRC_EN ? 16'h29B1 : 16'h0000);

    // 5: byte during HOLD is an overrun, payload untouched
    send(8'hAA);
    check("t5.overrun", 128'(overrun), 128'(1));
    check("t5.payload", 128'(payload), 128'(P_DIGITS));
    check("t5.fv", 128'(frame_valid), 128'(1));
    tick();
    check("t5.overrun_end", 128'(overrun), 128'(0));
    ack_frame("t5");

    // 6: framing error on byte 3 wins over its rx_valid, then reset mid-frame
    send(8'h11);
    send(8'h22);
    rx_frame_err = 1'b1;
    send(8'hEE);
    rx_frame_err = 1'b0;
    check("t6.err_framing", 128'(err_framing), 128'(1));
    check("t6.busy", 128'(busy), 128'(0));
    check("t6.payload", 128'(payload), 128'(72'h112233_343536373839));
    tick();
    check("t6.framing_end", 128'(err_framing), 128'(0));
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'hC5;
    tick();
    rx_valid = 1'b0;
    reset    = 1'b0;
    check_all_zero("t6.reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
